// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default-slave state type
// for the single-master interconnect.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } dflt_state_t;

endpackage

// File: rtl/ahb_dflt_slv.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with
// the two-cycle AHB ERROR response; IDLE/BUSY get zero-wait OKAY.
module ahb_dflt_slv
  import ahb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          i_hready,
  input  logic          i_dsel,
  input  logic          i_act,
  input  logic [1:0]    i_htrans,
  output logic [DW-1:0] o_hrdata,
  output logic [1:0]    o_hresp,
  output logic          o_hready,
  output logic          o_err_set
);

  dflt_state_t r_state;
  dflt_state_t w_nxt;
  logic        w_go;

  assign w_go     = i_hready & i_dsel & i_htrans[1];
  assign o_hrdata = '0;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= DS_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    o_err_set = 1'b0;
    unique case (r_state)
      DS_IDLE: begin
        if (w_go) begin
          w_nxt     = DS_ERR1;
          o_err_set = 1'b1;
        end
      end
      DS_ERR1: w_nxt = DS_ERR2;
      DS_ERR2: begin
        w_nxt     = w_go ? DS_ERR1 : DS_IDLE;
        o_err_set = w_go;
      end
      default: w_nxt = DS_IDLE;
    endcase
  end

  // Outputs depend on state only, keeping hready free of loops.
  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    unique case (r_state)
      DS_ERR1: begin
        o_hready = ~i_act;
        o_hresp  = i_act ? HRESP_ERROR : HRESP_OKAY;
      end
      DS_ERR2: o_hresp = i_act ? HRESP_ERROR : HRESP_OKAY;
      default: o_hresp = HRESP_OKAY;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: broadcast, window decode,
// return mux, default slave and sticky error/timeout status.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int SLV_C  = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 256
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [SLV_C*AW-1:0] haddr_base,
  input  logic [SLV_C*AW-1:0] haddr_mask,
  input  logic [AW-1:0]       haddr,
  input  logic [DW-1:0]       hwdata,
  input  logic                hwrite,
  input  logic [1:0]          htrans,
  input  logic [2:0]          hsize,
  input  logic [2:0]          hburst,
  output logic [DW-1:0]       hrdata,
  output logic [1:0]          hresp,
  output logic                hready,
  output logic [SLV_C*AW-1:0] haddr_s,
  output logic [SLV_C*DW-1:0] hwdata_s,
  output logic [SLV_C-1:0]    hwrite_s,
  output logic [SLV_C*2-1:0]  htrans_s,
  output logic [SLV_C*3-1:0]  hsize_s,
  output logic [SLV_C*3-1:0]  hburst_s,
  output logic [SLV_C-1:0]    hsel_s,
  input  logic [SLV_C*DW-1:0] hrdata_s,
  input  logic [SLV_C*2-1:0]  hresp_s,
  input  logic [SLV_C-1:0]    hready_s,
  output logic                err_valid,
  output logic [AW-1:0]       err_addr,
  output logic                to_flag,
  input  logic                stat_clr
);

  localparam int CW = $clog2(TO_CYC + 1);

  logic [SLV_C-1:0] w_hsel;
  logic             w_dsel;
  logic [SLV_C-1:0] r_sel_ff;
  logic             r_dsel_ff;
  logic             r_act_ff;
  logic [DW-1:0]    w_d_hrdata;
  logic [1:0]       w_d_hresp;
  logic             w_d_hready;
  logic             w_err_set;
  logic [CW-1:0]    r_cnt;
  logic             r_err_valid;
  logic [AW-1:0]    r_err_addr;
  logic             r_to_flag;

  assign haddr_s  = {SLV_C{haddr}};
  assign hwdata_s = {SLV_C{hwdata}};
  assign hwrite_s = {SLV_C{hwrite}};
  assign htrans_s = {SLV_C{htrans}};
  assign hsize_s  = {SLV_C{hsize}};
  assign hburst_s = {SLV_C{hburst}};

  // First matching window in index order wins.
  always_comb begin
    w_hsel = '0;
    w_dsel = 1'b1;
    for (int i = 0; i < SLV_C; i++) begin
      if (w_dsel &&
          ((haddr & haddr_mask[i*AW +: AW]) ==
           haddr_base[i*AW +: AW])) begin
        w_hsel[i] = 1'b1;
        w_dsel    = 1'b0;
      end
    end
  end

  assign hsel_s = w_hsel;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_sel_ff  <= '0;
      r_dsel_ff <= 1'b0;
      r_act_ff  <= 1'b0;
    end else if (hready) begin
      r_sel_ff  <= w_hsel;
      r_dsel_ff <= w_dsel;
      r_act_ff  <= htrans[1];
    end
  end

  always_comb begin
    hrdata = '0;
    hresp  = HRESP_OKAY;
    hready = 1'b1;
    if (r_dsel_ff) begin
      hrdata = w_d_hrdata;
      hresp  = w_d_hresp;
      hready = w_d_hready;
    end
    for (int i = 0; i < SLV_C; i++) begin
      if (r_sel_ff[i]) begin
        hrdata = hrdata_s[i*DW +: DW];
        hresp  = hresp_s[i*2 +: 2];
        hready = hready_s[i];
      end
    end
  end

  ahb_dflt_slv #(
    .DW(DW)
  ) u_dflt (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .i_hready (hready),
    .i_dsel   (w_dsel),
    .i_act    (r_act_ff),
    .i_htrans (htrans),
    .o_hrdata (w_d_hrdata),
    .o_hresp  (w_d_hresp),
    .o_hready (w_d_hready),
    .o_err_set(w_err_set)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)               r_cnt <= '0;
    else if (hready)            r_cnt <= '0;
    else if (r_cnt != CW'(TO_CYC)) r_cnt <= r_cnt + 1'b1;
  end

  // Clear has priority over any same-cycle set.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_to_flag   <= 1'b0;
    end else if (stat_clr) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_to_flag   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err_valid <= 1'b1;
        if (!r_err_valid) r_err_addr <= haddr;
      end
      if (!hready && r_cnt == CW'(TO_CYC - 1))
        r_to_flag <= 1'b1;
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign to_flag   = r_to_flag;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Random + directed bench for ahb_interconnect against a
// transfer-level model of the AHB-Lite return path and status.
module tb_ahb_interconnect;

  localparam int SLV_C  = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO_CYC = 8;

  logic                hclk = 1'b0;
  logic                hresetn;
  logic [SLV_C*AW-1:0] haddr_base;
  logic [SLV_C*AW-1:0] haddr_mask;
  logic [AW-1:0]       haddr;
  logic [DW-1:0]       hwdata;
  logic                hwrite;
  logic [1:0]          htrans;
  logic [2:0]          hsize;
  logic [2:0]          hburst;
  logic [DW-1:0]       hrdata;
  logic [1:0]          hresp;
  logic                hready;
  logic [SLV_C*AW-1:0] haddr_s;
  logic [SLV_C*DW-1:0] hwdata_s;
  logic [SLV_C-1:0]    hwrite_s;
  logic [SLV_C*2-1:0]  htrans_s;
  logic [SLV_C*3-1:0]  hsize_s;
  logic [SLV_C*3-1:0]  hburst_s;
  logic [SLV_C-1:0]    hsel_s;
  logic [SLV_C*DW-1:0] hrdata_s;
  logic [SLV_C*2-1:0]  hresp_s;
  logic [SLV_C-1:0]    hready_s;
  logic                err_valid;
  logic [AW-1:0]       err_addr;
  logic                to_flag;
  logic                stat_clr;

  logic [AW-1:0] base [SLV_C];
  logic [AW-1:0] mask [SLV_C];

  int n_chk  = 0;
  int n_pass = 0;

  int          m_tgt;
  bit          m_err;
  int          m_ph;
  bit          m_ev;
  logic [31:0] m_ea;
  bit          m_to;
  int          m_stall;
  bit          m_last_y;

  ahb_interconnect #(
    .SLV_C(SLV_C), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .haddr_base(haddr_base), .haddr_mask(haddr_mask),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hrdata(hrdata), .hresp(hresp), .hready(hready),
    .haddr_s(haddr_s), .hwdata_s(hwdata_s),
    .hwrite_s(hwrite_s), .htrans_s(htrans_s),
    .hsize_s(hsize_s), .hburst_s(hburst_s),
    .hsel_s(hsel_s), .hrdata_s(hrdata_s),
    .hresp_s(hresp_s), .hready_s(hready_s),
    .err_valid(err_valid), .err_addr(err_addr),
    .to_flag(to_flag), .stat_clr(stat_clr)
  );

  always #5 hclk = ~hclk;

  always_comb begin
    haddr_base = '0;
    haddr_mask = '0;
    for (int i = 0; i < SLV_C; i++) begin
      haddr_base[i*AW +: AW] = base[i];
      haddr_mask[i*AW +: AW] = mask[i];
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < SLV_C; i++)
      if ((a & mask[i]) == base[i]) return i;
    return SLV_C;
  endfunction

  task automatic mreset();
    m_tgt    = -1;
    m_err    = 0;
    m_ph     = 0;
    m_ev     = 0;
    m_ea     = '0;
    m_to     = 0;
    m_stall  = 0;
    m_last_y = 1;
  endtask

  task automatic step();
    logic [31:0] er;
    logic [1:0]  ep;
    logic        ey;
    logic [3:0]  eh;
    int          d;
    bit          to_set;
    bit          ev_set;
    @(negedge hclk);
    er = '0;
    ep = 2'b00;
    ey = 1'b1;
    if (m_tgt >= 0 && m_tgt < SLV_C) begin
      er = hrdata_s[m_tgt*DW +: DW];
      ep = hresp_s[m_tgt*2 +: 2];
      ey = hready_s[m_tgt];
    end else if (m_tgt == SLV_C && m_err) begin
      ep = 2'b01;
      ey = (m_ph == 1);
    end
    d  = dec(haddr);
    eh = (d < SLV_C) ? 4'(1 << d) : 4'b0000;
    chk("hready", hready, ey);
    chk("hresp", hresp, ep);
    chk("hrdata", hrdata, er);
    chk("hsel_s", hsel_s, eh);
    chk("err_valid", err_valid, m_ev);
    chk("err_addr", err_addr, m_ea);
    chk("to_flag", to_flag, m_to);
    chk("bc_addr", haddr_s, {SLV_C{haddr}});
    chk("bc_wdata", hwdata_s, {SLV_C{hwdata}});
    chk("bc_ctl", {hwrite_s, htrans_s, hsize_s, hburst_s},
        {{SLV_C{hwrite}}, {SLV_C{htrans}},
         {SLV_C{hsize}}, {SLV_C{hburst}}});
    @(posedge hclk);
    if (!hresetn) begin
      mreset();
    end else begin
      to_set = 0;
      if (ey) m_stall = 0;
      else if (m_stall < TO_CYC) begin
        m_stall++;
        to_set = (m_stall == TO_CYC);
      end
      ev_set = ey && (d == SLV_C) && htrans[1];
      if (stat_clr) begin
        m_ev = 0;
        m_ea = '0;
        m_to = 0;
      end else begin
        if (ev_set) begin
          if (!m_ev) m_ea = haddr;
          m_ev = 1;
        end
        if (to_set) m_to = 1;
      end
      if (ey) begin
        m_tgt = d;
        m_err = (d == SLV_C) && htrans[1];
        m_ph  = 0;
      end else if (m_tgt == SLV_C && m_err) begin
        m_ph = 1;
      end
      m_last_y = ey;
    end
    #1;
  endtask

  task automatic rnd_drive();
    int sel;
    if (m_last_y) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: haddr = {24'h000001, 8'($urandom)};
        1: haddr = {4'h0, 28'($urandom)};
        2: haddr = {4'h1, 28'($urandom)};
        3: haddr = {4'h2, 28'($urandom)};
        4: haddr = {4'h8, 28'($urandom)};
        5: haddr = {4'h9, 28'($urandom)};
        default: haddr = $urandom;
      endcase
      htrans = 2'($urandom);
      hwrite = 1'($urandom);
      hsize  = 3'($urandom);
      hburst = 3'($urandom);
    end
    hwdata   = $urandom;
    hrdata_s = {$urandom, $urandom, $urandom, $urandom};
    hresp_s  = 8'($urandom);
    for (int i = 0; i < SLV_C; i++)
      hready_s[i] = ($urandom_range(0, 3) != 0);
    stat_clr = ($urandom_range(0, 24) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    base[0] = 32'h0000_0000; mask[0] = 32'hF000_0000;
    base[1] = 32'h1000_0000; mask[1] = 32'hF000_0000;
    base[2] = 32'h0000_0100; mask[2] = 32'hFFFF_FF00;
    base[3] = 32'h2000_0000; mask[3] = 32'hF000_0000;
    hresetn  = 1'b0;
    haddr    = '0;
    hwdata   = '0;
    hwrite   = 1'b0;
    htrans   = 2'b00;
    hsize    = 3'd2;
    hburst   = 3'd0;
    hrdata_s = '0;
    hresp_s  = '0;
    hready_s = '1;
    stat_clr = 1'b0;
    mreset();
    step();
    step();
    hresetn = 1'b1;
    step();

    haddr  = 32'h1000_0004;
    htrans = 2'b10;
    #1 chk("t1_hsel", hsel_s, 4'b0010);
    step();
    htrans = 2'b00;
    haddr  = 32'h2000_0000;
    hready_s[1] = 1'b0;
    step();
    hready_s[1] = 1'b1;
    hrdata_s[63:32] = 32'hCAFE_F00D;
    #1 chk("t1_rdata", hrdata, 32'hCAFE_F00D);
    chk("t1_ok", {hready, hresp}, 3'b100);
    step();

    haddr  = 32'h8000_0000;
    htrans = 2'b10;
    hwrite = 1'b1;
    #1 chk("t2_hsel", hsel_s, 4'b0000);
    step();
    htrans = 2'b00;
    haddr  = 32'h0000_0000;
    #1 chk("t2_err1", {hready, hresp}, 3'b001);
    step();
    chk("t2_err2", {hready, hresp}, 3'b101);
    step();
    chk("t2_status", {err_valid, err_addr}, {1'b1, 32'h8000_0000});

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    haddr  = 32'h8000_0000;
    htrans = 2'b10;
    step();
    haddr  = 32'h9000_0000;
    step();
    step();
    htrans = 2'b00;
    step();
    step();
    chk("t3_first", {err_valid, err_addr}, {1'b1, 32'h8000_0000});
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("t3_clr", {err_valid, err_addr}, 33'd0);

    haddr  = 32'h8000_0000;
    htrans = 2'b00;
    step();
    step();
    chk("t4_idle", {hready, hresp, err_valid}, 4'b1000);

    haddr = 32'h0000_0100;
    #1 chk("t5_prio", hsel_s, 4'b0001);
    htrans = 2'b10;
    haddr  = 32'h0000_0000;
    step();
    htrans = 2'b00;
    hready_s[0] = 1'b0;
    for (int k = 0; k < TO_CYC - 1; k++) step();
    chk("t6_no_to", to_flag, 1'b0);
    step();
    chk("t6_to", to_flag, 1'b1);
    hready_s[0] = 1'b1;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;

    haddr  = 32'h8000_0000;
    htrans = 2'b10;
    step();
    htrans = 2'b00;
    #1 chk("t7_err1", hready, 1'b0);
    hresetn = 1'b0;
    mreset();
    #1 chk("t7_rst", {hready, hresp}, 3'b100);
    step();
    hresetn = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      rnd_drive();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
